fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising clk edge only.
REQ-003 stall  in  1  pipeline hazard stall; hold PC and IF outputs.
REQ-004 branch_valid  in  1  redirect request from ID/EX this cycle.
REQ-005 branch_target  in  32  redirect address; bits [1:0] ignored (forced 0).
REQ-006 irq  in  1  level interrupt request.
REQ-007 exc  in  1  exception (undefined instruction) pulse.
REQ-008 imem_addr  out  32  combinational address to instruction memory.
REQ-009 imem_data  in  32  combinational instruction memory read data for imem_addr.
REQ-010 dbg_req  in  1  debug readback request; held until dbg_ack.
REQ-011 dbg_addr  in  32  debug read address.
REQ-012 dbg_ack  out  1  one-cycle pulse; dbg_data valid same cycle.
REQ-013 dbg_data  out  32  registered debug read data.
REQ-014 if_pc  out  32  IF/ID register: PC of fetched instruction.
REQ-015 if_instr  out  32  IF/ID register: fetched instruction.
REQ-016 if_valid  out  1  IF/ID register: 0 = bubble.

Function
REQ-017 PC register 32 bits, always word aligned; PC[31] = kernel mode.
REQ-018 Vectors: reset 0x80000000, irq 0x80000004, exc 0x80000008.
REQ-019 States: RUN, DBG. imem_addr = PC in RUN, dbg_addr (bits [1:0] = 0) in DBG.
REQ-020 RUN next-PC priority: exc > irq (only if PC[31]=0) > branch_valid > stall > debug steal > PC+4.
REQ-021 exc/irq/branch: next PC = vector/target; if_valid <= 0 (flush of wrong-path fetch); stall ignored.
REQ-022 stall (no redirect): PC, if_pc, if_instr, if_valid hold.
REQ-023 Sequential: PC <= PC+4; if_pc <= PC; if_instr <= imem_data; if_valid <= 1; 32-bit wrap 0xFFFFFFFC -> 0x00000000.
REQ-024 Fetch latency: instruction at address PC appears on if_instr one cycle after PC presented.
REQ-025 Debug grant: RUN -> DBG when dbg_req=1 and no redirect and (stall=1 or starve counter = 3).
REQ-026 Starve counter 2 bits: increments each RUN cycle with dbg_req=1 and no grant; saturates at 3; clears on grant or dbg_req=0.
REQ-027 DBG lasts exactly one cycle: dbg_data <= imem_data, dbg_ack = 1 next cycle, return to RUN; PC holds.
REQ-028 DBG entered without stall: if_valid <= 0 (bubble); with stall: IF outputs hold.
REQ-029 Redirect arriving while in DBG: debug read completes; redirect applied that cycle to PC, if_valid <= 0.
REQ-030 dbg_ack asserted only in cycle after DBG; dbg_req must drop the cycle after ack; new request restarts counter.
REQ-031 irq with PC[31]=1 ignored (no nesting); exc taken in any mode.

Reset
REQ-032 On reset: PC = 0x80000000, state RUN, starve counter 0, if_pc = 0, if_instr = 0, if_valid = 0, dbg_ack = 0, dbg_data = 0.
REQ-033 reset overrides all inputs, including in DBG (pending debug read abandoned, no ack).
REQ-034 First cycle after reset release: imem_addr = 0x80000000.

Verification
REQ-035 Reset release, no stimulus 4 cycles -> imem_addr 0x80000000, 04, 08, 0C; if_valid 0,1,1,1; if_pc follows one cycle behind.
REQ-036 branch_valid=1, branch_target=0x8000001C while stall=1 -> next imem_addr 0x8000001C, if_valid 0.
REQ-037 PC=0x00000010, irq=1 and branch_valid=1 same cycle -> next PC 0x80000004; with PC=0x80000010, irq ignored.
REQ-038 exc and irq same cycle -> next PC 0x80000008, if_valid 0.
REQ-039 dbg_req=1, dbg_addr=0x80000014, stall=0 continuous -> 3 counted cycles, grant on 4th, dbg_ack next cycle with dbg_data = word at 0x80000014, one bubble, PC resumes unchanged.
REQ-040 reset asserted during DBG cycle -> no dbg_ack, all outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction-fetch front end. Owns the program counter,
//                arbitrates between exception / interrupt / branch redirects,
//                pipeline stalls and sequential fetch, drives the combinational
//                instruction-memory address, and fills the IF/ID register.
//                A debug port can steal one instruction-memory cycle to read
//                an arbitrary word; a starvation counter guarantees the steal
//                eventually happens even if the pipeline never stalls.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   system clock, all state on rising edge
//    reset          in   synchronous active-high reset
//    stall          in   pipeline hazard stall (hold PC and IF/ID)
//    branch_valid   in   redirect request from ID/EX
//    branch_target  in   redirect address, bits [1:0] ignored
//    irq            in   level interrupt request (taken only in user mode)
//    exc            in   exception pulse (taken in any mode)
//    imem_addr      out  combinational instruction-memory address
//    imem_data      in   combinational instruction-memory read data
//    dbg_req        in   debug read request, held until dbg_ack
//    dbg_addr       in   debug read address, bits [1:0] ignored
//    dbg_ack        out  one-cycle pulse, dbg_data valid in the same cycle
//    dbg_data       out  registered debug read data
//    if_pc          out  IF/ID: PC of fetched instruction
//    if_instr       out  IF/ID: fetched instruction
//    if_valid       out  IF/ID: 0 = bubble
// ============================================================================
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_ack,
  output logic [31:0] dbg_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0]  c_st_run    = 1'b0;
  localparam logic [0:0]  c_st_dbg    = 1'b1;

  localparam logic [31:0] c_vec_reset = 32'h8000_0000;
  localparam logic [31:0] c_vec_irq   = 32'h8000_0004;
  localparam logic [31:0] c_vec_exc   = 32'h8000_0008;

  localparam logic [1:0]  c_starve_max = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [1:0]  r_starve;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_if_valid;
  logic        r_dbg_ack;
  logic [31:0] r_dbg_data;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic        w_in_run;
  logic        w_irq_take;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_grant;
  logic [31:0] w_pc_inc;

  // Address alignment drops the low two bits of both external addresses.
  logic        w_unused_bits;
  assign w_unused_bits = ^{branch_target[1:0], dbg_addr[1:0]};

  assign w_in_run   = (r_state == c_st_run);

  // PC[31] marks kernel mode; interrupts do not nest.
  assign w_irq_take = irq & ~r_pc[31];
  assign w_redirect = exc | w_irq_take | branch_valid;

  always_comb begin
    w_redirect_pc = {branch_target[31:2], 2'b00};
    if (exc) begin
      w_redirect_pc = c_vec_exc;
    end else if (w_irq_take) begin
      w_redirect_pc = c_vec_irq;
    end
  end

  // Debug steal: taken for free during a stall, otherwise only once the
  // request has been starved for three cycles. The ack cycle is excluded so
  // a request still held high while the ack is seen cannot re-trigger.
  assign w_grant = w_in_run & dbg_req & ~w_redirect & ~r_dbg_ack &
                   (stall | (r_starve == c_starve_max));

  // Natural 32-bit wrap: 0xFFFFFFFC + 4 = 0x00000000.
  assign w_pc_inc = r_pc + 32'd4;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_run;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic (DBG always lasts exactly one cycle)
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_run: begin
        if (w_grant) begin
          w_state_nxt = c_st_dbg;
        end
      end
      c_st_dbg: begin
        w_state_nxt = c_st_run;
      end
      default: begin
        w_state_nxt = c_st_run;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic -- memory port belongs to the debug read while in DBG
  // --------------------------------------------------------------------------
  always_comb begin
    imem_addr = r_pc;
    case (r_state)
      c_st_dbg: imem_addr = {dbg_addr[31:2], 2'b00};
      default:  imem_addr = r_pc;
    endcase
  end

  // --------------------------------------------------------------------------
  // Starvation counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= 2'd0;
    end else if (!w_in_run || !dbg_req || w_grant || r_dbg_ack) begin
      r_starve <= 2'd0;
    end else if (r_starve != c_starve_max) begin
      r_starve <= r_starve + 2'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Debug read return
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dbg_ack  <= 1'b0;
      r_dbg_data <= 32'd0;
    end else begin
      r_dbg_ack <= ~w_in_run;
      if (!w_in_run) begin
        r_dbg_data <= imem_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // PC and IF/ID register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= c_vec_reset;
      r_if_pc    <= 32'd0;
      r_if_instr <= 32'd0;
      r_if_valid <= 1'b0;
    end else if (w_redirect) begin
      // Redirects win over stall, in RUN and in DBG alike; the word at the
      // old PC is on the wrong path and is dropped.
      r_pc       <= w_redirect_pc;
      r_if_valid <= 1'b0;
    end else if (!w_in_run || w_grant) begin
      // Memory cycle is (or is about to be) used by the debug read, so no
      // instruction is fetched. PC holds; IF/ID holds under stall, else
      // a bubble goes down the pipe.
      if (!stall) begin
        r_if_valid <= 1'b0;
      end
    end else if (!stall) begin
      r_pc       <= w_pc_inc;
      r_if_pc    <= r_pc;
      r_if_instr <= imem_data;
      r_if_valid <= 1'b1;
    end
  end

  assign dbg_ack  = r_dbg_ack;
  assign dbg_data = r_dbg_data;
  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;
  assign if_valid = r_if_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. A combinational
//                memory model answers imem_addr; fetched PCs are queued when
//                the fetch is launched and compared when they reach IF/ID.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        irq;
  logic        exc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .irq           (irq),
    .exc           (exc),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .dbg_req       (dbg_req),
    .dbg_addr      (dbg_addr),
    .dbg_ack       (dbg_ack),
    .dbg_data      (dbg_data),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_valid      (if_valid)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_data = mem(imem_addr);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_valid = 0; branch_target = 0;
    irq = 0; exc = 0; dbg_req = 0; dbg_addr = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    cyc();
    reset = 0;
    sb_q.delete();
  endtask

  task automatic redirect_to(input logic [31:0] t);
    branch_valid  = 1;
    branch_target = t;
    cyc();
    branch_valid  = 0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    cyc();
    cyc();
    checks++; if (imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL rst_imem_addr got=%h exp=80000000", imem_addr); end
    checks++; if (if_pc !== 32'd0)       begin errors++; $display("FAIL rst_if_pc got=%h exp=0", if_pc); end
    checks++; if (if_instr !== 32'd0)    begin errors++; $display("FAIL rst_if_instr got=%h exp=0", if_instr); end
    checks++; if (if_valid !== 1'b0)     begin errors++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
    checks++; if (dbg_ack !== 1'b0)      begin errors++; $display("FAIL rst_dbg_ack got=%b exp=0", dbg_ack); end
    checks++; if (dbg_data !== 32'd0)    begin errors++; $display("FAIL rst_dbg_data got=%h exp=0", dbg_data); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_addr = 32'h8000_0000 + 32'(4 * i);
      checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imem_addr, exp_addr); end
      checks++; if (if_valid !== (i > 0)) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=%b", i, if_valid, (i > 0)); end
      if (i > 0) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL seq_sb_empty[%0d]", i); end
        else begin
          exp_pc = sb_q.pop_front();
          if (if_pc !== exp_pc || if_instr !== mem(exp_pc)) begin
            errors++; $display("FAIL seq_ifid[%0d] got pc=%h instr=%h exp pc=%h instr=%h", i, if_pc, if_instr, exp_pc, mem(exp_pc));
          end
        end
      end
      sb_q.push_back(exp_addr);
      cyc();
    end
  endtask

  task automatic test_stall();
    // Entry: PC=0x80000010, IF/ID holds 0x8000000C (still queued).
    stall = 1;
    cyc();
    cyc();
    checks++; if (imem_addr !== 32'h8000_0010) begin errors++; $display("FAIL stall_addr got=%h exp=80000010", imem_addr); end
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", if_valid); end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL stall_sb_empty"); end
    else begin
      exp_pc = sb_q.pop_front();
      if (if_pc !== exp_pc || if_instr !== mem(exp_pc)) begin
        errors++; $display("FAIL stall_ifid got pc=%h instr=%h exp pc=%h", if_pc, if_instr, exp_pc);
      end
    end
    stall = 0;
    sb_q.push_back(32'h8000_0010);
    cyc();
    checks++; if (imem_addr !== 32'h8000_0014) begin errors++; $display("FAIL stall_resume_addr got=%h exp=80000014", imem_addr); end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL stall_resume_sb_empty"); end
    else begin
      exp_pc = sb_q.pop_front();
      if (if_pc !== exp_pc || if_instr !== mem(exp_pc) || if_valid !== 1'b1) begin
        errors++; $display("FAIL stall_resume_ifid got pc=%h v=%b exp pc=%h", if_pc, if_valid, exp_pc);
      end
    end
  endtask

  task automatic test_branch_stall();
    stall = 1;
    branch_valid  = 1;
    branch_target = 32'h8000_001E;   // low bits must be dropped
    cyc();
    stall = 0;
    branch_valid = 0;
    sb_q.delete();
    checks++; if (imem_addr !== 32'h8000_001C) begin errors++; $display("FAIL br_stall_addr got=%h exp=8000001c", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_stall_valid got=%b exp=0", if_valid); end
    sb_q.push_back(32'h8000_001C);
    cyc();
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL br_sb_empty"); end
    else begin
      exp_pc = sb_q.pop_front();
      if (if_pc !== exp_pc || if_instr !== mem(exp_pc) || if_valid !== 1'b1) begin
        errors++; $display("FAIL br_target_ifid got pc=%h v=%b exp pc=%h", if_pc, if_valid, exp_pc);
      end
    end
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFF_FFFF);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_addr got=%h exp=fffffffc", imem_addr); end
    sb_q.push_back(32'hFFFF_FFFC);
    cyc();
    checks++; if (imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr got=%h exp=00000000", imem_addr); end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL wrap_sb_empty"); end
    else begin
      exp_pc = sb_q.pop_front();
      if (if_pc !== exp_pc || if_instr !== mem(exp_pc) || if_valid !== 1'b1) begin
        errors++; $display("FAIL wrap_ifid got pc=%h v=%b exp pc=%h", if_pc, if_valid, exp_pc);
      end
    end
  endtask

  task automatic test_irq();
    redirect_to(32'h0000_0010);      // user mode
    irq = 1; branch_valid = 1; branch_target = 32'h8000_0100;
    cyc();
    irq = 0; branch_valid = 0;
    checks++; if (imem_addr !== 32'h8000_0004) begin errors++; $display("FAIL irq_user_addr got=%h exp=80000004", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL irq_user_valid got=%b exp=0", if_valid); end
    redirect_to(32'h8000_0010);      // kernel mode: irq must be ignored
    irq = 1;
    sb_q.push_back(32'h8000_0010);
    cyc();
    checks++; if (imem_addr !== 32'h8000_0014) begin errors++; $display("FAIL irq_kernel_addr got=%h exp=80000014", imem_addr); end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL irq_sb_empty"); end
    else begin
      exp_pc = sb_q.pop_front();
      if (if_pc !== exp_pc || if_instr !== mem(exp_pc) || if_valid !== 1'b1) begin
        errors++; $display("FAIL irq_kernel_ifid got pc=%h v=%b exp pc=%h", if_pc, if_valid, exp_pc);
      end
    end
    branch_valid = 1; branch_target = 32'h8000_0100;   // irq still high
    cyc();
    irq = 0; branch_valid = 0;
    checks++; if (imem_addr !== 32'h8000_0100) begin errors++; $display("FAIL irq_kernel_branch got=%h exp=80000100", imem_addr); end
  endtask

  task automatic test_exc();
    redirect_to(32'h0000_0020);
    exc = 1; irq = 1; branch_valid = 1; branch_target = 32'h8000_0300;
    cyc();
    exc = 0; irq = 0; branch_valid = 0;
    checks++; if (imem_addr !== 32'h8000_0008) begin errors++; $display("FAIL exc_irq_addr got=%h exp=80000008", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL exc_irq_valid got=%b exp=0", if_valid); end
    redirect_to(32'h8000_0040);
    exc = 1;
    cyc();
    exc = 0;
    checks++; if (imem_addr !== 32'h8000_0008) begin errors++; $display("FAIL exc_kernel_addr got=%h exp=80000008", imem_addr); end
  endtask

  task automatic test_debug_starve();
    logic [31:0] exp_addr;
    redirect_to(32'h8000_0040);
    dbg_req  = 1;
    dbg_addr = 32'h8000_0017;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(32'h8000_0040 + 32'(4 * i));
      cyc();
      exp_addr = 32'h8000_0044 + 32'(4 * i);
      checks++; if (imem_addr !== exp_addr || dbg_ack !== 1'b0) begin errors++; $display("FAIL dbg_count[%0d] got addr=%h ack=%b exp addr=%h ack=0", i, imem_addr, dbg_ack, exp_addr); end
      checks++;
      if (sb_q.size() == 0) begin errors++; $display("FAIL dbg_sb_empty[%0d]", i); end
      else begin
        exp_pc = sb_q.pop_front();
        if (if_pc !== exp_pc || if_instr !== mem(exp_pc) || if_valid !== 1'b1) begin
          errors++; $display("FAIL dbg_count_ifid[%0d] got pc=%h v=%b exp pc=%h", i, if_pc, if_valid, exp_pc);
        end
      end
    end
    cyc();   // grant
    checks++; if (imem_addr !== 32'h8000_0014) begin errors++; $display("FAIL dbg_grant_addr got=%h exp=80000014", imem_addr); end
    checks++; if (if_valid !== 1'b0 || dbg_ack !== 1'b0) begin errors++; $display("FAIL dbg_grant_ifv_ack got v=%b ack=%b exp v=0 ack=0", if_valid, dbg_ack); end
    cyc();   // DBG cycle completes
    checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL dbg_ack got=%b exp=1", dbg_ack); end
    checks++; if (dbg_data !== mem(32'h8000_0014)) begin errors++; $display("FAIL dbg_data got=%h exp=%h", dbg_data, mem(32'h8000_0014)); end
    checks++; if (imem_addr !== 32'h8000_004C || if_valid !== 1'b0) begin errors++; $display("FAIL dbg_resume got addr=%h v=%b exp addr=8000004c v=0", imem_addr, if_valid); end
    dbg_req = 0;
    sb_q.push_back(32'h8000_004C);
    cyc();
    checks++; if (dbg_ack !== 1'b0 || imem_addr !== 32'h8000_0050) begin errors++; $display("FAIL dbg_after got ack=%b addr=%h exp ack=0 addr=80000050", dbg_ack, imem_addr); end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL dbg_after_sb_empty"); end
    else begin
      exp_pc = sb_q.pop_front();
      if (if_pc !== exp_pc || if_instr !== mem(exp_pc) || if_valid !== 1'b1) begin
        errors++; $display("FAIL dbg_after_ifid got pc=%h v=%b exp pc=%h", if_pc, if_valid, exp_pc);
      end
    end
  endtask

  task automatic test_debug_stall_redirect();
    // Entry: IF/ID holds valid 0x8000004C, PC=0x80000050.
    stall    = 1;
    dbg_req  = 1;
    dbg_addr = 32'h8000_0024;
    cyc();   // immediate grant under stall
    checks++; if (imem_addr !== 32'h8000_0024) begin errors++; $display("FAIL dbgs_addr got=%h exp=80000024", imem_addr); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_004C) begin errors++; $display("FAIL dbgs_hold got v=%b pc=%h exp v=1 pc=8000004c", if_valid, if_pc); end
    branch_valid = 1; branch_target = 32'h8000_0200;
    cyc();
    branch_valid = 0; dbg_req = 0; stall = 0;
    checks++; if (dbg_ack !== 1'b1 || dbg_data !== mem(32'h8000_0024)) begin errors++; $display("FAIL dbgs_ack got ack=%b data=%h exp ack=1 data=%h", dbg_ack, dbg_data, mem(32'h8000_0024)); end
    checks++; if (imem_addr !== 32'h8000_0200 || if_valid !== 1'b0) begin errors++; $display("FAIL dbgs_redirect got addr=%h v=%b exp addr=80000200 v=0", imem_addr, if_valid); end
    cyc();
  endtask

  task automatic test_reset_in_dbg();
    stall    = 1;
    dbg_req  = 1;
    dbg_addr = 32'h8000_0030;
    cyc();   // now in DBG
    checks++; if (imem_addr !== 32'h8000_0030) begin errors++; $display("FAIL rdbg_enter got=%h exp=80000030", imem_addr); end
    reset = 1;
    cyc();
    checks++; if (dbg_ack !== 1'b0 || dbg_data !== 32'd0) begin errors++; $display("FAIL rdbg_dbg got ack=%b data=%h exp ack=0 data=0", dbg_ack, dbg_data); end
    checks++; if (imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL rdbg_addr got=%h exp=80000000", imem_addr); end
    checks++; if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_instr !== 32'd0) begin errors++; $display("FAIL rdbg_ifid got v=%b pc=%h instr=%h exp 0", if_valid, if_pc, if_instr); end
    reset = 0;
    clear_inputs();
    cyc();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL rdbg_no_ack got=%b exp=0", dbg_ack); end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_wrap();
    test_irq();
    test_exc();
    test_debug_starve();
    test_debug_stall_redirect();
    test_reset_in_dbg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
`default_nettype wire
